regwrite_queue: RTL
===================

# regwrite_queue

Write-back queue that sits directly upstream of the 32 x 32-bit register array and drives its per-register write enables. Producers push (address, data) write requests via a valid/ready handshake. The queue buffers up to DEPTH of them and drains one per cycle into the array unless the array stalls. A combinational lookup port lets readers see the youngest still-queued value for an address, so buffered writes are never invisible.

## Interface
Parameters:
- DEPTH, 4, number of queue entries (power of two, ≥ 2)
- AW, 5, register address width (2^AW registers)
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset; asynchronous, active-high
- wr_valid  in  1  producer has a write request
- wr_ready  out  1  queue can accept; equals (count < DEPTH)
- wr_addr  in  AW  destination register
- wr_data  in  DW  value to write
- rf_stall  in  1  array cannot take a write this cycle
- rf_we  out  2^AW  one-hot write enable to array (all zero when idle)
- rf_data  out  DW  data for the enabled register
- lk_addr  in  AW  lookup address
- lk_hit  out  1  a queued entry targets lk_addr
- lk_data  out  DW  data of youngest matching entry (0 when no hit)
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: circular buffer of DEPTH entries {addr, data}; head pointer rd_ptr, tail pointer wr_ptr, occupancy count.
- Push: wr_valid && wr_ready at an edge. Writes to address 0 are accepted (handshake completes) but not stored; register 0 stays zero.
- Pop: occurs at an edge when count > 0 && !rf_stall. rf_we = one-hot(head.addr) and rf_data = head.data in that same cycle; otherwise rf_we = 0 and rf_data = 0.
- Simultaneous push and pop: both happen; count unchanged.
- Pointers wrap modulo DEPTH.
- Push while full: impossible; wr_ready is low.
- Pop on empty: suppressed.
- Lookup: compare lk_addr against every valid entry and select the youngest match by age from the tail. Address 0 never hits.
- Ordering: entries drain strictly in acceptance order. Repeated writes to one address are all applied, oldest first.

## Timing
- Reset (async, on clr high): rd_ptr = wr_ptr = count = 0, storage addr fields 0, rf_we = 0, rf_data = 0, wr_ready = 1, lk_hit = 0, lk_data = 0. Takes effect immediately, mid-operation included. Queued entries are discarded.
- Latency: a request accepted at edge N appears on rf_we in cycle N+1 at earliest (no combinational pass-through). The array commits it at edge N+1.
- wr_ready, rf_we and rf_data depend only on registered state. rf_we and rf_data also depend on rf_stall, combinationally.
- lk_hit and lk_data are combinational from lk_addr and registered state. An entry pushed at edge N is visible from cycle N+1. It stops being visible once popped, when the array holds the value.
- wr_ready deasserts in the cycle after count reaches DEPTH. It does not rise in the same cycle as a concurrent pop.

## Structure
- Shared package regfile_pkg: AW, DW, NREGS = 2^AW, and the typedef wb_entry_t {addr, data}. The register array and this queue both import it.
- One sub-module: onehot_dec (AW → 2^AW decoder), reused by the array's read side.
- The array instantiates register32 per register with wEnable = rf_we[i], in = rf_data, reset = clr.

## Test plan
- Reset then idle: clr pulse → count=0, wr_ready=1, rf_we=0, lk_hit=0.
- Single write: push (addr 5, 0xDEADBEEF) at edge 1 with rf_stall=0 → cycle 2 rf_we=32'h20, rf_data=0xDEADBEEF, count returns to 0 after edge 2.
- Fill and stall: rf_stall=1, push addrs 1,2,3,4 → count=4, wr_ready=0. Release stall → rf_we shows 1,2,3,4 on four consecutive cycles.
- Youngest lookup: stall, push (7,0x11) then (7,0x22), lk_addr=7 → lk_hit=1, lk_data=0x22. Release → 0x11 written before 0x22.
- Address 0 and simultaneous push/pop: push (0,0xFFFF) → accepted, count stays 0, no rf_we. With count=2 and no stall, push and pop in one cycle → count stays 2, pointers wrap past DEPTH-1 correctly.
- Reset mid-drain: count=3, assert clr between edges → outputs zero immediately; after release, no queued write reaches rf_we.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry and write-back entry type
package regfile_pkg;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NREGS = 2 ** AW;
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: binary index to one-hot select
module onehot_dec #(
   parameter int AW = regfile_pkg::AW
) (
   input  logic [AW-1:0]      idx,
   output logic [2**AW-1:0]   onehot
);
   assign onehot = {{(2**AW-1){1'b0}}, 1'b1} << idx;
endmodule

// File: rtl/regwrite_queue.sv
// regwrite_queue: buffered write-back queue feeding the register array, with youngest-match lookup
module regwrite_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = regfile_pkg::AW,
   parameter int DW    = regfile_pkg::DW,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DW-1:0]     wr_data,
   input  logic              rf_stall,
   output logic [2**AW-1:0]  rf_we,
   output logic [DW-1:0]     rf_data,
   input  logic [AW-1:0]     lk_addr,
   output logic              lk_hit,
   output logic [DW-1:0]     lk_data,
   output logic [CW-1:0]     count
);
   logic [AW-1:0]    q_addr [DEPTH];
   logic [DW-1:0]    q_data [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [2**AW-1:0] head_sel;
   logic             store, pop;

   assign wr_ready = count < CW'(DEPTH);
   // register 0 is hardwired: its writes complete the handshake but are dropped
   assign store = wr_valid && wr_ready && wr_addr != '0;
   assign pop   = count != '0 && !rf_stall;

   onehot_dec #(.AW(AW)) u_dec (.idx(q_addr[rd_ptr]), .onehot(head_sel));

   assign rf_we   = pop ? head_sel : '0;
   assign rf_data = pop ? q_data[rd_ptr] : '0;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) q_addr[i] <= '0;
      end else begin
         if (store) q_addr[wr_ptr] <= wr_addr;
         wr_ptr <= wr_ptr + PW'(store);
         rd_ptr <= rd_ptr + PW'(pop);
         count  <= count + CW'(store) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (store) q_data[wr_ptr] <= wr_data;
   end

   // scan oldest to youngest so the last match wins
   always_comb begin
      lk_hit  = 1'b0;
      lk_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count && lk_addr != '0 && q_addr[PW'(rd_ptr + PW'(i))] == lk_addr) begin
            lk_hit  = 1'b1;
            lk_data = q_data[PW'(rd_ptr + PW'(i))];
         end
      end
   end
endmodule
